// File: rtl/taxi_disp_pkg.sv
// Shared definitions for the taximeter 7-segment display path: segment
// patterns, digit codes and the scan-capture FSM encoding.
package taxi_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIG_BLANK   = 4'hF;
    localparam logic [3:0] DIG_ILLEGAL = 4'hE;

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_HELD = 1'b1
    } cap_state_e;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg7_decode_sub.sv
// Combinational inverse of the seg7ment_sub encoder: active-high abcdefg
// pattern back to a digit code, flagging patterns the scanner never drives.
module seg7_decode_sub
    import taxi_disp_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       illegal
);

    // Pattern lookup; anything outside the table decodes as illegal.
    always_comb begin
        code    = DIG_ILLEGAL;
        illegal = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = DIG_BLANK;
            default: begin
                code    = DIG_ILLEGAL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of the multiplexed 7-segment bus: settles each scanned digit,
// assembles 4-digit frames and publishes a frame once it has been stable.
module seg7_scan_capture
    import taxi_disp_pkg::*;
#(
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1,
    parameter int SETTLE      = 4,
    parameter int STABLE_FRM  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  a_to_g,
    input  logic [3:0]  enable,
    input  logic        point,
    output logic [15:0] out_digit,
    output logic [3:0]  out_dp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_seg,
    output logic        err_an,
    output logic        overrun
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);
    localparam logic [3:0] STABLE_C = 4'(STABLE_FRM);

    logic [3:0]  en_s;
    logic [6:0]  seg_s;
    logic        dp_s;
    logic [11:0] sample_s;
    logic [11:0] samp_r;
    logic        changed_s;

    cap_state_e  state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
    logic        capture_s, an_err_s;

    logic [3:0]  dec_code_s;
    logic        dec_illegal_s;

    logic [15:0] slot_r;
    logic [3:0]  dp_r;
    logic [3:0]  mask_r;

    logic [19:0] prev_frm_r;
    logic [3:0]  match_r, match_nxt_s;
    logic        frame_done_s, publish_s, first_done_r;
    logic [19:0] cand_s;

    assign en_s      = (AN_ACT_LOW != 0)  ? ~enable : enable;
    assign seg_s     = (SEG_ACT_LOW != 0) ? ~a_to_g : a_to_g;
    assign dp_s      = (SEG_ACT_LOW != 0) ? ~point  : point;
    assign sample_s  = {en_s, seg_s, dp_s};
    assign changed_s = (sample_s != samp_r);
    assign cnt_inc_s = (cnt_r >= SETTLE_C) ? SETTLE_C : (cnt_r + 8'd1);

    seg7_decode_sub u_decode (
        .seg     (seg_s),
        .code    (dec_code_s),
        .illegal (dec_illegal_s)
    );

    // Capture FSM: multi-hot selects share the settle counter but only raise err_an.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        an_err_s    = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (changed_s || (en_s == 4'd0)) begin
                    cnt_nxt_s = 8'd1;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                    if (cnt_inc_s == SETTLE_C) begin
                        state_nxt_s = ST_HELD;
                        if (is_one_hot(en_s)) begin
                            capture_s = 1'b1;
                        end else begin
                            an_err_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
            end
            ST_HELD: begin
                if (changed_s) begin
                    state_nxt_s = ST_HUNT;
                    cnt_nxt_s   = 8'd1;
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
                cnt_nxt_s   = 8'd1;
            end
        endcase
    end

    // Sampler and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_r  <= 12'd0;
            state_r <= ST_HUNT;
            cnt_r   <= 8'd0;
        end else begin
            samp_r  <= sample_s;
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign frame_done_s = (mask_r == 4'hF);
    assign cand_s       = {slot_r, dp_r};

    // Slot capture; a completed frame clears the mask in the cycle it is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r <= 16'd0;
            dp_r   <= 4'd0;
            mask_r <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (capture_s && en_s[i]) begin
                    slot_r[i*4 +: 4] <= dec_code_s;
                    dp_r[i]          <= dp_s;
                    mask_r[i]        <= 1'b1;
                end else if (frame_done_s) begin
                    mask_r[i] <= 1'b0;
                end
            end
        end
    end

    // Frame stability: count identical consecutive frames, saturating at 15.
    always_comb begin
        match_nxt_s = 4'd1;
        if (cand_s == prev_frm_r) begin
            match_nxt_s = (match_r == 4'd15) ? 4'd15 : (match_r + 4'd1);
        end else begin
            match_nxt_s = 4'd1;
        end
    end

    assign publish_s = frame_done_s && (match_nxt_s >= STABLE_C) &&
                       (!first_done_r || (cand_s != {out_digit, out_dp}));

    // Frame comparator history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_frm_r <= 20'd0;
            match_r    <= 4'd0;
        end else if (frame_done_s) begin
            prev_frm_r <= cand_s;
            match_r    <= match_nxt_s;
        end
    end

    // Output register, handshake and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_digit    <= 16'd0;
            out_dp       <= 4'd0;
            out_valid    <= 1'b0;
            first_done_r <= 1'b0;
            err_seg      <= 1'b0;
            err_an       <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (publish_s) begin
                out_digit    <= slot_r;
                out_dp       <= dp_r;
                out_valid    <= 1'b1;
                first_done_r <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (capture_s && dec_illegal_s) begin
                err_seg <= 1'b1;
            end
            if (an_err_s) begin
                err_an <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: drives an active-low scanned bus and
// checks published frames, handshake, sticky errors and async reset.
module tb_seg7_scan_capture;

    localparam logic [6:0] P0 = 7'h7E, P1 = 7'h30, P2 = 7'h6D, P3 = 7'h79, P4 = 7'h33;
    localparam logic [6:0] P5 = 7'h5B, P6 = 7'h5F, P7 = 7'h70, P8 = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  a_to_g;
    logic [3:0]  enable;
    logic        point;
    logic [15:0] out_digit;
    logic [3:0]  out_dp;
    logic        out_valid;
    logic        out_ready;
    logic        err_seg, err_an, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int acc_base;

    seg7_scan_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_to_g    (a_to_g),
        .enable    (enable),
        .point     (point),
        .out_digit (out_digit),
        .out_dp    (out_dp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_seg   (err_seg),
        .err_an    (err_an),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) n_acc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] pat, input logic dp, input int n);
        logic [3:0] sel;
        sel    = 4'b0001 << idx;
        enable = ~sel;
        a_to_g = ~pat;
        point  = ~dp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                        input logic [6:0] p0, input logic [3:0] dps);
        drive_digit(3, p3, dps[3], 8);
        drive_digit(2, p2, dps[2], 8);
        drive_digit(1, p1, dps[1], 8);
        drive_digit(0, p0, dps[0], 8);
    endtask

    task automatic do_reset();
        enable = 4'hF;
        a_to_g = 7'h7F;
        point  = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        out_ready = 1'b0;
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_digit", 32'(out_digit), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_errs", 32'({err_seg, err_an, overrun}), 32'h0);
        do_reset();

        // First frame needs a second identical frame before it is published
        scan(P1, P2, P3, P4, 4'b0000);
        chk("one_frame_no_pub", 32'(out_valid), 32'h0);
        scan(P1, P2, P3, P4, 4'b0000);
        chk("pub_valid", 32'(out_valid), 32'h1);
        chk("pub_digit", 32'(out_digit), 32'h1234);
        chk("pub_dp", 32'(out_dp), 32'h0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("accept_clears", 32'(out_valid), 32'h0);

        // Held display publishes once
        do_reset();
        acc_base = n_acc;
        for (int i = 0; i < 10; i++) scan(P1, P2, P3, P4, 4'b0000);
        chk("held_one_pub", 32'(n_acc - acc_base), 32'd1);
        chk("held_no_valid", 32'(out_valid), 32'h0);

        // Illegal pattern on digit 2
        out_ready = 1'b0;
        scan(P1, 7'h01, P3, P4, 4'b0000);
        scan(P1, 7'h01, P3, P4, 4'b0000);
        chk("illegal_digit", 32'(out_digit), 32'h1E34);
        chk("err_seg_set", 32'(err_seg), 32'h1);
        scan(P5, P6, P7, P8, 4'b0000);
        scan(P5, P6, P7, P8, 4'b0000);
        chk("err_seg_sticky", 32'(err_seg), 32'h1);
        chk("overrun_replace", 32'({overrun, out_digit}), 32'h15678);

        // Glitching segments never settle
        do_reset();
        for (int i = 0; i < 10; i++) drive_digit(3, (i % 2 == 0) ? P1 : P2, 1'b0, 2);
        chk("glitch_mask", 32'(dut.mask_r), 32'h0);
        chk("glitch_valid", 32'(out_valid), 32'h0);

        // Multi-hot select
        do_reset();
        enable = ~4'b0011;
        a_to_g = ~P1;
        point  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("err_an_set", 32'(err_an), 32'h1);
        chk("multihot_mask", 32'(dut.mask_r), 32'h0);
        scan(P5, P6, P7, P8, 4'b0000);
        scan(P5, P6, P7, P8, 4'b0000);
        chk("after_an_digit", 32'(out_digit), 32'h5678);
        chk("after_an_valid", 32'(out_valid), 32'h1);

        // Overrun then async reset mid-scan
        do_reset();
        scan(P0, P0, P0, P1, 4'b0100);
        scan(P0, P0, P0, P1, 4'b0100);
        chk("first_pub", 32'({overrun, out_dp, out_digit}), 32'h0_4_0001);
        scan(P0, P0, P0, P2, 4'b0010);
        scan(P0, P0, P0, P2, 4'b0010);
        chk("overrun_set", 32'(overrun), 32'h1);
        chk("overrun_data", 32'({out_dp, out_digit}), 32'h2_0002);
        chk("overrun_valid", 32'(out_valid), 32'h1);
        drive_digit(3, P1, 1'b1, 3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'({out_dp, out_digit}), 32'h0);
        chk("async_rst_flags", 32'({out_valid, err_seg, err_an, overrun}), 32'h0);
        chk("async_rst_mask", 32'(dut.mask_r), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
